dm_responder: RTL and testbench

Byte-addressed data-memory responder that serves load/store requests from the multi-cycle MIPS core over a req/ready handshake. It owns the 1 KB data array and performs sub-word merging (sb/sh read-modify-write) and load extension (lb/lbu/lh/lhu) internally, so the core no longer reads the array directly. It sits between the core's ALU-address/store-data registers and the memory-data register.

---
 rtl/dm_responder.sv | 92 +++++++++
 tb/tb_dm_responder.sv | 111 +++++++++++
 2 files changed

// File: rtl/dm_responder.sv
// dm_responder: byte-addressed 1 KB data memory with sub-word merge and load extension behind a req/ready handshake
module dm_responder #(
  parameter int ADDR_W = 10
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req_i,
  input  logic              we_i,
  input  logic [1:0]        size_i,
  input  logic              sext_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       wdata_i,
  output logic              ready_o,
  output logic [31:0]       rdata_o,
  output logic              err_o,
  output logic              busy_o
);
  localparam int DEPTH = 2 ** (ADDR_W - 2);
  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_e;
  state_e state_q, state_d;
  logic              we_q, sext_q, err_q;
  logic [1:0]        size_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q, rdata_q, merge_q, rd_q;
  logic [31:0]       mem_q [DEPTH];
  logic              accept, illegal;
  logic [7:0]        lane_b;
  logic [15:0]       lane_h;
  logic [31:0]       load_val, wrep, mask, wr_word;
  logic [3:0]        be;
  // acceptance, legality and datapath lane steering
  always_comb begin
    accept   = state_q == IDLE && req_i;
    illegal  = size_i == 2'b11 || (size_i == 2'b01 && addr_i[0]) || (size_i == 2'b10 && addr_i[1:0] != 2'b00);
    lane_b   = rd_q[{addr_q[1:0], 3'b000} +: 8];
    lane_h   = addr_q[1] ? rd_q[31:16] : rd_q[15:0];
    load_val = size_q == 2'b00 ? {{24{sext_q & lane_b[7]}}, lane_b} :
               size_q == 2'b01 ? {{16{sext_q & lane_h[15]}}, lane_h} : rd_q;
    be       = size_q == 2'b00 ? 4'b0001 << addr_q[1:0] :
               size_q == 2'b01 ? (addr_q[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    wrep     = size_q == 2'b00 ? {4{wdata_q[7:0]}} : size_q == 2'b01 ? {2{wdata_q[15:0]}} : wdata_q;
    mask     = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    wr_word  = (wrep & mask) | (merge_q & ~mask);
  end
  // state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else state_q <= state_d;
  end
  // next-state: illegal goes straight to RESP, word stores skip the read
  always_comb begin
    state_d = state_q == IDLE  ? (req_i ? (illegal ? RESP : (we_i && size_i == 2'b10) ? WRITE : READ) : IDLE) :
              state_q == READ  ? (we_q ? WRITE : RESP) :
              state_q == WRITE ? RESP : IDLE;
  end
  // outputs decoded from state
  always_comb begin
    ready_o = state_q == RESP;
    err_o   = ready_o & err_q;
    busy_o  = state_q != IDLE;
    rdata_o = rdata_q;
  end
  // request capture, load result and merge register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      we_q    <= 1'b0;
      sext_q  <= 1'b0;
      err_q   <= 1'b0;
      size_q  <= 2'b00;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      merge_q <= '0;
    end else begin
      if (accept) begin
        we_q    <= we_i;
        sext_q  <= sext_i;
        err_q   <= illegal;
        size_q  <= size_i;
        addr_q  <= addr_i;
        wdata_q <= wdata_i;
      end
      if (state_q == READ && we_q) merge_q <= rd_q;
      if (state_q == READ && !we_q) rdata_q <= load_val;
    end
  end
  // data array: registered read on acceptance, write in WRITE; contents survive reset
  always_ff @(posedge clk_i) begin
    if (accept) rd_q <= mem_q[addr_i[ADDR_W-1:2]];
    if (state_q == WRITE) mem_q[addr_q[ADDR_W-1:2]] <= wr_word;
  end
endmodule

// File: tb/tb_dm_responder.sv
// tb_dm_responder: directed checks of dm_responder stores, loads, merging, errors, back-to-back and reset abort
module tb_dm_responder;
  logic        clk = 1'b0, rst_n = 1'b0, req = 1'b0, we = 1'b0, sext = 1'b0;
  logic [1:0]  size = 2'b00;
  logic [9:0]  addr = '0;
  logic [31:0] wdata = '0, rdata;
  logic        ready, err, busy;
  int          n_cmp = 0, n_bad = 0;
  dm_responder #(.ADDR_W(10)) dut (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .we_i(we), .size_i(size), .sext_i(sext),
    .addr_i(addr), .wdata_i(wdata), .ready_o(ready), .rdata_o(rdata), .err_o(err), .busy_o(busy)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask
  task automatic acc(input logic w, input logic [1:0] sz, input logic sx, input logic [9:0] a,
                     input logic [31:0] wd, input int exp_lat, input logic exp_err, input string tag);
    int lat;
    @(negedge clk);
    req = 1'b1; we = w; size = sz; sext = sx; addr = a; wdata = wd;
    @(posedge clk);
    #1;
    req = 1'b0; we = ~w; size = ~sz; sext = ~sx; addr = ~a; wdata = ~wd;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) chk({tag, "_busy"}, 32'(busy), 32'd1);
    end while (!ready && lat < 8);
    chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_err"}, 32'(err), 32'(exp_err));
  endtask
  initial begin
    int n, seen;
    #12;
    chk("rst_ready", 32'(ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    acc(1, 2'b10, 0, 10'h010, 32'hDEADBEEF, 2, 0, "sw10");
    chk("sw_rdata_kept", rdata, 32'd0);
    acc(0, 2'b10, 0, 10'h010, 32'h0, 2, 0, "lw10");
    chk("lw10_data", rdata, 32'hDEADBEEF);
    acc(1, 2'b00, 0, 10'h012, 32'hFFFFFF5A, 3, 0, "sb12");
    chk("sb_rdata_kept", rdata, 32'hDEADBEEF);
    acc(0, 2'b10, 0, 10'h010, 32'h0, 2, 0, "lw10b");
    chk("lw10b_data", rdata, 32'hDE5ABEEF);
    acc(0, 2'b00, 1, 10'h012, 32'h0, 2, 0, "lb12");
    chk("lb12_data", rdata, 32'h0000005A);
    acc(0, 2'b00, 1, 10'h013, 32'h0, 2, 0, "lb13");
    chk("lb13_data", rdata, 32'hFFFFFFDE);
    acc(0, 2'b00, 0, 10'h013, 32'h0, 2, 0, "lbu13");
    chk("lbu13_data", rdata, 32'h000000DE);
    acc(1, 2'b01, 0, 10'h012, 32'h77778001, 3, 0, "sh12");
    acc(0, 2'b01, 1, 10'h012, 32'h0, 2, 0, "lh12");
    chk("lh12_data", rdata, 32'hFFFF8001);
    acc(0, 2'b01, 0, 10'h012, 32'h0, 2, 0, "lhu12");
    chk("lhu12_data", rdata, 32'h00008001);
    acc(0, 2'b10, 0, 10'h010, 32'h0, 2, 0, "lw10c");
    chk("lw10c_data", rdata, 32'h8001BEEF);
    acc(0, 2'b01, 0, 10'h010, 32'h0, 2, 0, "lhu10");
    chk("lhu10_data", rdata, 32'h0000BEEF);
    acc(0, 2'b10, 0, 10'h011, 32'h0, 1, 1, "lw11");
    chk("lw11_rdata", rdata, 32'h0000BEEF);
    acc(1, 2'b01, 0, 10'h013, 32'h0000FFFF, 1, 1, "sh13");
    acc(0, 2'b11, 0, 10'h010, 32'h0, 1, 1, "sz11");
    chk("sz11_rdata", rdata, 32'h0000BEEF);
    acc(0, 2'b10, 0, 10'h010, 32'h0, 2, 0, "lw10d");
    chk("lw10d_data", rdata, 32'h8001BEEF);
    acc(1, 2'b10, 0, 10'h014, 32'hCAFEF00D, 2, 0, "sw14");
    @(negedge clk);
    req = 1'b1; we = 1'b0; size = 2'b10; sext = 1'b1; addr = 10'h010;
    n = 0;
    do begin @(negedge clk); n++; end while (!ready && n < 8);
    chk("b2b_lat", 32'(n), 32'd2);
    chk("b2b_d0", rdata, 32'h8001BEEF);
    addr = 10'h014;
    n = 0;
    do begin @(negedge clk); n++; end while (!ready && n < 8);
    chk("b2b_gap", 32'(n), 32'd3);
    chk("b2b_d1", rdata, 32'hCAFEF00D);
    req = 1'b0;
    acc(1, 2'b10, 0, 10'h020, 32'h11223344, 2, 0, "sw20");
    @(negedge clk);
    req = 1'b1; we = 1'b1; size = 2'b00; sext = 1'b0; addr = 10'h020; wdata = 32'h000000AA;
    @(posedge clk);
    #1;
    req = 1'b0;
    chk("sb20_busy", 32'(busy), 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_rdata", rdata, 32'd0);
    seen = 0;
    repeat (4) begin @(negedge clk); seen |= int'(ready); end
    chk("abort_no_ready", 32'(seen), 32'd0);
    rst_n = 1'b1;
    acc(0, 2'b10, 0, 10'h020, 32'h0, 2, 0, "lw20");
    chk("lw20_data", rdata, 32'h11223344);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
